// File: rtl/fixed_matmul_stream.sv
// Streaming fixed-point tile matmul C = A x B^T. The first pass captures A into a replay RAM; the
// remaining column tiles reuse it. Define FIXED_MATMUL_STREAM_ROUND_EN for round-half-up requantisation.
module fixed_matmul_stream #(
    parameter int IN1_WIDTH           = 8,
    parameter int IN1_FRAC_WIDTH      = 4,
    parameter int IN2_WIDTH           = 8,
    parameter int IN2_FRAC_WIDTH      = 4,
    parameter int OUT_WIDTH           = 8,
    parameter int OUT_FRAC_WIDTH      = 4,
    parameter int IN1_PARALLELISM     = 2,
    parameter int IN2_PARALLELISM     = 2,
    parameter int IN_SIZE             = 2,
    parameter int IN_DEPTH            = 3,
    parameter int IN2_NUM_PARALLELISM = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [IN1_PARALLELISM*IN_SIZE-1:0][IN1_WIDTH-1:0]  data_in1,
    input  logic                                               data_in1_valid,
    output logic                                               data_in1_ready,
    input  logic [IN2_PARALLELISM*IN_SIZE-1:0][IN2_WIDTH-1:0]  data_in2,
    input  logic                                               data_in2_valid,
    output logic                                               data_in2_ready,
    output logic [IN1_PARALLELISM*IN2_PARALLELISM-1:0][OUT_WIDTH-1:0] data_out,
    output logic                                               data_out_valid,
    input  logic                                               data_out_ready,
    output logic                                               data_out_last,
    output logic                                               overflow
);
    localparam int NA    = IN1_PARALLELISM * IN_SIZE;
    localparam int NC    = IN1_PARALLELISM * IN2_PARALLELISM;
    localparam int PW    = IN1_WIDTH + IN2_WIDTH;
    localparam int AW    = PW + $clog2(IN_SIZE * IN_DEPTH);
    localparam int AW1   = AW + 1;
    localparam int SHIFT = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int BCW   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int PCW   = (IN2_NUM_PARALLELISM > 1) ? $clog2(IN2_NUM_PARALLELISM) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(IN_DEPTH - 1);
    localparam logic [PCW-1:0] LAST_PASS = PCW'(IN2_NUM_PARALLELISM - 1);
    localparam logic signed [AW:0] OMAX = {{(AW + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] OMIN = ~OMAX;
`ifdef FIXED_MATMUL_STREAM_ROUND_EN
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] RND = (SHIFT > 0) ? (ONE <<< RSH) : '0;
`endif

    typedef enum logic [0:0] {FIRST = 1'b0, REPLAY = 1'b1} state_t;

    // Bit OUT_WIDTH of the result flags saturation.
    function automatic logic [OUT_WIDTH:0] requant(input logic signed [AW-1:0] v);
        logic signed [AW:0] t;
        t = AW1'(v);
`ifdef FIXED_MATMUL_STREAM_ROUND_EN
        t = t + RND;
`endif
        t = t >>> SHIFT;
        if (t > OMAX) begin
            requant = {1'b1, OMAX[OUT_WIDTH-1:0]};
        end else if (t < OMIN) begin
            requant = {1'b1, OMIN[OUT_WIDTH-1:0]};
        end else begin
            requant = {1'b0, t[OUT_WIDTH-1:0]};
        end
    endfunction

    state_t                         state_q, state_d;
    logic [BCW-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [PCW-1:0]                 pass_cnt_q, pass_cnt_d;
    logic signed [AW-1:0]           acc_q [NC];
    logic signed [AW-1:0]           acc_d [NC];
    logic [NC-1:0][OUT_WIDTH-1:0]   data_out_q, data_out_d;
    logic                           data_out_valid_q, data_out_valid_d;
    logic                           data_out_last_q, data_out_last_d;
    logic                           overflow_q, overflow_d;
    logic [NA-1:0][IN1_WIDTH-1:0]   ram_q [IN_DEPTH];
    logic [NA-1:0][IN1_WIDTH-1:0]   rd_q, rd_d, a_beat_s;
    logic                           slot_ok_s, last_beat_s, adv_s, accept_s, load_s, ram_we_s;
    logic signed [AW-1:0]           dot_s;
    logic signed [PW-1:0]           prod_s;
    logic [OUT_WIDTH:0]             rq_s;

    // Handshake, datapath and next-state computation.
    always_comb begin
        slot_ok_s      = !data_out_valid_q || data_out_ready;
        last_beat_s    = (beat_cnt_q == LAST_BEAT);
        adv_s          = !last_beat_s || slot_ok_s;
        data_in1_ready = 1'b0;
        data_in2_ready = 1'b0;
        accept_s       = 1'b0;
        ram_we_s       = 1'b0;
        a_beat_s       = rd_q;
        case (state_q)
            FIRST: begin
                data_in1_ready = data_in2_valid && adv_s;
                data_in2_ready = data_in1_valid && adv_s;
                accept_s       = data_in1_valid && data_in2_valid && adv_s;
                ram_we_s       = accept_s;
                a_beat_s       = data_in1;
            end
            REPLAY: begin
                data_in2_ready = adv_s;
                accept_s       = data_in2_valid && adv_s;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
        load_s = accept_s && last_beat_s;

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (load_s) begin
            beat_cnt_d = '0;
            if (pass_cnt_q == LAST_PASS) begin
                pass_cnt_d = '0;
                state_d    = FIRST;
            end else begin
                pass_cnt_d = pass_cnt_q + PCW'(1);
                state_d    = REPLAY;
            end
        end else if (accept_s) begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        // The read address follows the next beat so replay data lines up with the B beat.
        rd_d = (ram_we_s && (beat_cnt_d == beat_cnt_q)) ? data_in1 : ram_q[beat_cnt_d];

        data_out_d       = data_out_q;
        data_out_last_d  = data_out_last_q;
        overflow_d       = overflow_q;
        data_out_valid_d = data_out_valid_q;
        if (load_s) begin
            data_out_valid_d = 1'b1;
            data_out_last_d  = (pass_cnt_q == LAST_PASS);
        end else if (data_out_ready) begin
            data_out_valid_d = 1'b0;
        end else begin
            data_out_valid_d = data_out_valid_q;
        end

        acc_d  = acc_q;
        dot_s  = '0;
        prod_s = '0;
        rq_s   = '0;
        for (int i = 0; i < IN1_PARALLELISM; i++) begin
            for (int j = 0; j < IN2_PARALLELISM; j++) begin
                dot_s = '0;
                for (int k = 0; k < IN_SIZE; k++) begin
                    prod_s = PW'($signed(a_beat_s[i*IN_SIZE+k])) * PW'($signed(data_in2[j*IN_SIZE+k]));
                    dot_s  = dot_s + AW'(prod_s);
                end
                if (accept_s) begin
                    acc_d[i*IN2_PARALLELISM+j] = (beat_cnt_q == '0) ? dot_s : acc_q[i*IN2_PARALLELISM+j] + dot_s;
                end else begin
                    acc_d[i*IN2_PARALLELISM+j] = acc_q[i*IN2_PARALLELISM+j];
                end
                rq_s = requant(acc_d[i*IN2_PARALLELISM+j]);
                if (load_s) begin
                    data_out_d[i*IN2_PARALLELISM+j] = rq_s[OUT_WIDTH-1:0];
                    overflow_d = overflow_d | rq_s[OUT_WIDTH];
                end else begin
                    data_out_d[i*IN2_PARALLELISM+j] = data_out_q[i*IN2_PARALLELISM+j];
                end
            end
        end
    end

    // Control state, accumulators and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= FIRST;
            beat_cnt_q       <= '0;
            pass_cnt_q       <= '0;
            acc_q            <= '{default: '0};
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            data_out_last_q  <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            pass_cnt_q       <= pass_cnt_d;
            acc_q            <= acc_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_last_q  <= data_out_last_d;
            overflow_q       <= overflow_d;
        end
    end

    // Replay RAM and its registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[beat_cnt_q] <= data_in1;
        end
        rd_q <= rd_d;
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign data_out_last  = data_out_last_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_fixed_matmul_stream.sv
// Directed self-checking bench for fixed_matmul_stream at default parameters.
module tb_fixed_matmul_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in1, data_in2, data_out;
    logic        data_in1_valid, data_in1_ready, data_in2_valid, data_in2_ready;
    logic        data_out_valid, data_out_ready, data_out_last, overflow;
    int          errors = 0;
    int          checks = 0;
    logic [32:0] tile_q [$];

`ifdef FIXED_MATMUL_STREAM_ROUND_EN
    localparam logic [31:0] EXP_POS = 32'h00000101;
    localparam logic [31:0] EXP_NEG = 32'h00000000;
`else
    localparam logic [31:0] EXP_POS = 32'h00000000;
    localparam logic [31:0] EXP_NEG = 32'h0000FFFF;
`endif

    fixed_matmul_stream dut (
        .clk(clk), .rst(rst),
        .data_in1(data_in1), .data_in1_valid(data_in1_valid), .data_in1_ready(data_in1_ready),
        .data_in2(data_in2), .data_in2_valid(data_in2_valid), .data_in2_ready(data_in2_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) tile_q.push_back({data_out_last, data_out});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        data_in1 = 32'h0; data_in2 = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        tile_q.delete();
    endtask

    task automatic beat(input logic first, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        data_in1 = a; data_in2 = b; data_in1_valid = first; data_in2_valid = 1'b1;
        @(negedge clk);
        while (!(data_in2_ready && (!first || data_in1_ready)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL beat_timeout: got no handshake after %0d cycles, required within 20", n);
        end
        @(posedge clk); #1;
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
    endtask

    task automatic run_block(input logic [31:0] a0, input logic [31:0] arest,
                             input logic [31:0] b0, input logic [31:0] b1);
        for (int n = 0; n < 3; n++) beat(1'b1, (n == 0) ? a0 : arest, b0);
        for (int n = 0; n < 3; n++) beat(1'b0, 32'h0, b1);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        data_in1 = 32'h0; data_in2 = 32'h0; data_out_ready = 1'b1;
        #2;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data_out); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
        checks++; if (data_out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", data_out_last); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (data_in1_ready !== 1'b0) begin errors++; $display("FAIL reset_in1_ready: got %b want 0", data_in1_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b1;
        for (int n = 0; n < 3; n++) beat(1'b1, 32'h10101010, 32'h10101010);
        checks++;
        if (data_out_valid !== 1'b1 || data_out_last !== 1'b0) begin
            errors++; $display("FAIL latency_first: got valid=%b last=%b want valid=1 last=0", data_out_valid, data_out_last);
        end
        for (int n = 0; n < 3; n++) beat(1'b0, 32'h0, 32'h10101010);
        checks++;
        if (data_out_valid !== 1'b1 || data_out_last !== 1'b1) begin
            errors++; $display("FAIL latency_replay: got valid=%b last=%b want valid=1 last=1", data_out_valid, data_out_last);
        end
        run_block(32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010);
        drain();
        checks++; if (tile_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d tiles want 4", tile_q.size()); end
        for (int n = 0; n < 4 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++;
            if (t !== {n[0], 32'h60606060}) begin errors++; $display("FAIL basic_tile%0d: got %h want %h", n, t, {n[0], 32'h60606060}); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_saturate();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b1;
        run_block(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL satpos_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t[31:0] !== 32'h7F7F7F7F) begin errors++; $display("FAIL satpos_tile%0d: got %h want 7f7f7f7f", n, t[31:0]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL satpos_overflow: got %b want 1", overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_reset_overflow: got %b want 0", overflow); end
        run_block(32'h80808080, 32'h80808080, 32'h7F7F7F7F, 32'h7F7F7F7F);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL satneg_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t[31:0] !== 32'h80808080) begin errors++; $display("FAIL satneg_tile%0d: got %h want 80808080", n, t[31:0]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL satneg_overflow: got %b want 1", overflow); end
    endtask

    task automatic test_backpressure();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b0;
        for (int n = 0; n < 3; n++) beat(1'b1, 32'h10101010, 32'h10101010);
        beat(1'b0, 32'h0, 32'h08080808);
        beat(1'b0, 32'h0, 32'h08080808);
        data_in2 = 32'h08080808; data_in2_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (data_in2_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got ready=%b want 0", n, data_in2_ready); end
            checks++;
            if (data_out_valid !== 1'b1 || data_out !== 32'h60606060) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1 60606060", n, data_out_valid, data_out);
            end
        end
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (data_in2_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ready=%b want 1", data_in2_ready); end
        @(posedge clk); #1;
        data_in2_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 32'h30303030 || data_out_last !== 1'b1) begin
            errors++; $display("FAIL bp_swap: got valid=%b data=%h last=%b want 1 30303030 1", data_out_valid, data_out, data_out_last);
        end
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d want 2", tile_q.size()); end
        if (tile_q.size() == 2) begin
            t = tile_q.pop_front();
            checks++; if (t !== {1'b0, 32'h60606060}) begin errors++; $display("FAIL bp_tile0: got %h want 060606060", t); end
            t = tile_q.pop_front();
            checks++; if (t !== {1'b1, 32'h30303030}) begin errors++; $display("FAIL bp_tile1: got %h want 130303030", t); end
        end
    endtask

    task automatic test_rounding();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b1;
        run_block(32'h00000001, 32'h0, 32'h08080808, 32'h08080808);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL rndpos_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t[31:0] !== EXP_POS) begin errors++; $display("FAIL rndpos_tile%0d: got %h want %h", n, t[31:0], EXP_POS); end
        end
        do_reset();
        run_block(32'h000000FF, 32'h0, 32'h08080808, 32'h08080808);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL rndneg_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t[31:0] !== EXP_NEG) begin errors++; $display("FAIL rndneg_tile%0d: got %h want %h", n, t[31:0], EXP_NEG); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_no_b();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b1;
        data_in1 = 32'h20202020; data_in1_valid = 1'b1; data_in2_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (data_in1_ready !== 1'b0) begin errors++; $display("FAIL nob_ready%0d: got %b want 0", n, data_in1_ready); end
        end
        @(posedge clk); #1;
        data_in1_valid = 1'b0;
        run_block(32'h20202020, 32'h10101010, 32'h08080808, 32'h08080808);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL nob_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t !== {n[0], 32'h40404040}) begin errors++; $display("FAIL nob_tile%0d: got %h want %h", n, t, {n[0], 32'h40404040}); end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] t;
        do_reset();
        data_out_ready = 1'b0;
        for (int n = 0; n < 3; n++) beat(1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F);
        beat(1'b0, 32'h0, 32'h7F7F7F7F);
        checks++;
        if (data_out_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got valid=%b overflow=%b want 1 1", data_out_valid, overflow);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 32'h0 || data_out_valid !== 1'b0 || data_out_last !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got data=%h valid=%b last=%b ovf=%b want all 0", data_out, data_out_valid, data_out_last, overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        data_out_ready = 1'b1;
        tile_q.delete();
        run_block(32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010);
        drain();
        checks++; if (tile_q.size() != 2) begin errors++; $display("FAIL mid_count: got %0d want 2", tile_q.size()); end
        for (int n = 0; n < 2 && tile_q.size() > 0; n++) begin
            t = tile_q.pop_front();
            checks++; if (t !== {n[0], 32'h60606060}) begin errors++; $display("FAIL mid_tile%0d: got %h want %h", n, t, {n[0], 32'h60606060}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_rounding();
        test_no_b();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
